mips_multicycle_core: RTL

Parametrised multi-cycle successor to the 16-bit single-cycle MIPS datapath. Executes the team's 16-bit instruction set, plus jump and halt, over a DATA_W-wide datapath. A per-instruction state machine sequences fetch, decode, execute, memory and write-back. All instruction and data traffic uses one unified memory port with a variable-latency req/ack handshake. The block is the processor top; memory and test benches attach at the memory port.

---
 rtl/mips_mc_pkg.sv | 69 ++++++
 rtl/mips_mc_if.sv | 25 ++
 rtl/mips_mc_regfile.sv | 48 ++++
 rtl/mips_multicycle_core.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle 16-bit MIPS core.
// Holds the instruction field positions, the opcode map, the control
// state encoding and the ALU operation encoding, plus small decode helpers
// so the top level and any future block agree on one instruction format.
package mips_mc_pkg;

   localparam int OP_MSB = 15;
   localparam int OP_LSB = 12;
   localparam int RS_MSB = 11;
   localparam int RS_LSB = 8;
   localparam int RT_MSB = 7;
   localparam int RT_LSB = 4;
   localparam int RD_MSB = 3;
   localparam int RD_LSB = 0;
   localparam int JT_MSB = 11;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_SLT  = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_LW   = 4'h6;
   localparam logic [3:0] OP_SW   = 4'h7;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_BNE  = 4'h9;
   localparam logic [3:0] OP_J    = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALTED
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   // Address arithmetic (ADDI, LW, SW) and anything without a dedicated
   // operation falls back to addition.
   function automatic alu_op_t aluOpFor(input logic [3:0] op);
      case (op)
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   // Opcodes B..E are unassigned and are retired as no-ops.
   function automatic logic isIllegalOp(input logic [3:0] op);
      return (op >= 4'hB) && (op <= 4'hE);
   endfunction

   // Opcodes 0..4 write rd; ADDI and LW write rt.
   function automatic logic isRType(input logic [3:0] op);
      return op <= OP_SLT;
   endfunction

endpackage

// File: rtl/mips_mc_if.sv
// Unified instruction/data memory port of the multi-cycle MIPS core.
// The core (master) drives mem_req/mem_we/mem_addr/mem_wdata and holds
// them until the memory (slave) answers with mem_ack; mem_rdata is only
// meaningful in the cycle mem_ack is high.
interface mips_mc_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mips_mc_regfile.sv
// Register file for the multi-cycle MIPS core.
// Ports: clk, reset (async, active-low clear), two combinational read
// ports (rs/rt address in, data out) and one write port committed on the
// rising clock edge. Register 0 and any index at or above NREGS read as
// zero and ignore writes.
module mips_mc_regfile #(
   parameter int DATA_W = 16,
   parameter int NREGS  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        rs_addr_i,
   input  logic [3:0]        rt_addr_i,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   input  logic              we_i,
   input  logic [3:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i
);

   localparam logic [4:0] NREGS_L = 5'(NREGS);

   logic [DATA_W-1:0] regs_q [NREGS];

   function automatic logic isLive(input logic [3:0] idx);
      return (idx != 4'd0) && ({1'b0, idx} < NREGS_L);
   endfunction

   // Both read ports are combinational so DECODE sees a value written in
   // the previous WB cycle without an extra bypass.
   always_comb begin
      rs_data_o = '0;
      rt_data_o = '0;
      if (isLive(rs_addr_i)) rs_data_o = regs_q[rs_addr_i];
      if (isLive(rt_addr_i)) rt_data_o = regs_q[rt_addr_i];
   end

   // Whole array clears while reset is low; writes to R0 are dropped here
   // so the read side never has to special-case a stale R0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we_i && isLive(waddr_i)) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle 16-bit-ISA MIPS core with a single req/ack memory port.
// Ports: clk, reset (async, active-low), bus (mips_mc_if master: request,
// write enable, address, write data out; read data and ack in), pc (debug
// view of the program counter), halted (core stopped on HALT), illegal
// (one-cycle pulse after decoding an undefined opcode).
module mips_multicycle_core
   import mips_mc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int NREGS  = 16
) (
   input  logic              clk,
   input  logic              reset,
   mips_mc_if.master         bus,
   output logic [ADDR_W-1:0] pc,
   output logic              halted,
   output logic              illegal
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
   logic              req_q, req_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              halted_q, halted_d, illegal_q, illegal_d;

   logic [3:0]        opcode;
   logic [DATA_W-1:0] immData, opB, aluRes, rsData, rtData, wbData;
   logic [ADDR_W-1:0] immAddr;
   logic [3:0]        wbAddr;
   logic              wbEn, useImm;

   assign opcode  = ir_q[OP_MSB:OP_LSB];
   assign immData = {{(DATA_W-4){ir_q[RD_MSB]}}, ir_q[RD_MSB:RD_LSB]};
   assign immAddr = {{(ADDR_W-4){ir_q[RD_MSB]}}, ir_q[RD_MSB:RD_LSB]};
   assign useImm  = (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
   assign wbEn    = (state_q == WB);
   assign wbAddr  = isRType(opcode) ? ir_q[RD_MSB:RD_LSB] : ir_q[RT_MSB:RT_LSB];
   assign wbData  = (opcode == OP_LW) ? mdr_q : alu_q;

   assign bus.mem_req   = req_q;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign pc            = pc_q;
   assign halted        = halted_q;
   assign illegal       = illegal_q;

   mips_mc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
      .clk       (clk),
      .reset     (reset),
      .rs_addr_i (ir_q[RS_MSB:RS_LSB]),
      .rt_addr_i (ir_q[RT_MSB:RT_LSB]),
      .rs_data_o (rsData),
      .rt_data_o (rtData),
      .we_i      (wbEn),
      .waddr_i   (wbAddr),
      .wdata_i   (wbData)
   );

   // ALU works on the operands latched in DECODE; the immediate replaces B
   // for ADDI and for the load/store effective address.
   always_comb begin
      aluRes = '0;
      opB    = useImm ? immData : b_q;
      case (aluOpFor(opcode))
         ALU_ADD: aluRes = a_q + opB;
         ALU_SUB: aluRes = a_q - opB;
         ALU_AND: aluRes = a_q & opB;
         ALU_OR:  aluRes = a_q | opB;
         ALU_SLT: aluRes = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(opB))};
         default: aluRes = a_q + opB;
      endcase
   end

   // Every bus output is registered. Whenever control returns to FETCH the
   // next fetch is launched on that same edge (addressed by the updated PC),
   // so a zero-wait fetch costs one cycle; only the first fetch after reset
   // spends a cycle raising the request from FETCH itself.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      halted_d  = halted_q;
      illegal_d = 1'b0;
      case (state_q)
         FETCH: begin
            if (!req_q) begin
               req_d  = 1'b1;
               we_d   = 1'b0;
               addr_d = pc_q;
            end else if (bus.mem_ack) begin
               ir_d    = bus.mem_rdata[15:0];
               pc_d    = pc_q + ADDR_W'(1);
               req_d   = 1'b0;
               state_d = DECODE;
            end
         end
         DECODE: begin
            a_d = rsData;
            b_d = rtData;
            if (opcode == OP_J) begin
               pc_d    = {pc_q[ADDR_W-1:12], ir_q[JT_MSB:0]};
               state_d = FETCH;
            end else if (opcode == OP_HALT) begin
               halted_d = 1'b1;
               state_d  = HALTED;
            end else if (isIllegalOp(opcode)) begin
               illegal_d = 1'b1;
               state_d   = FETCH;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            alu_d = aluRes;
            if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
               if ((a_q == b_q) == (opcode == OP_BEQ)) pc_d = pc_q + immAddr;
               state_d = FETCH;
            end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
               req_d   = 1'b1;
               we_d    = (opcode == OP_SW);
               addr_d  = aluRes[ADDR_W-1:0];
               wdata_d = b_q;
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            if (bus.mem_ack) begin
               req_d = 1'b0;
               we_d  = 1'b0;
               if (opcode == OP_LW) begin
                  mdr_d   = bus.mem_rdata;
                  state_d = WB;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         WB: begin
            state_d = FETCH;
         end
         HALTED: begin
            req_d = 1'b0;
            we_d  = 1'b0;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
      if ((state_d == FETCH) && (state_q != FETCH)) begin
         req_d  = 1'b1;
         we_d   = 1'b0;
         addr_d = pc_d;
      end
   end

   // State register; reset drops the request immediately so an ack that
   // arrives during or after reset finds nothing outstanding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         pc_q      <= '0;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_q     <= '0;
         mdr_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_q     <= alu_d;
         mdr_q     <= mdr_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

endmodule
